// File: rtl/rcc_ahb_if_if.sv
// AHB-Lite bus bundle for the RCC register slave: address/data-phase inputs
// from the master plus the slave's HREADYOUT/HRESP response.
interface rcc_ahb_if_if #(
    parameter int ADDR_W = 12
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic              HREADY;
    logic [31:0]       HWDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HREADYOUT, HRESP
    );
endinterface

// File: rtl/rcc_ahb_if.sv
// AHB-Lite slave front end for the RCC scale register.
// Decodes offset 0x000 (scale register) and turns each legal address phase
// into a one-cycle data-phase strobe; illegal accesses get the two-cycle
// AHB ERROR response (ERR1: wait + ERROR, ERR2: ready + ERROR).
// Optional feature: define RCC_AHB_LOCK_EN to add a write lock on 0x000,
// released by writing the key 32'hC0DE_5A5A to offset 0x004.
module rcc_ahb_if #(
    parameter int ADDR_W = 12
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    rcc_ahb_if_if.slave  ahb,
    output logic         HSEL_REG,
    output logic         HWRITE_REG,
    output logic [2:0]   HSIZE_REG,
    output logic         RD_SEL,
    output logic [2:0]   RD_SIZE,
    output logic         LOCKED
);

    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic        addr_vld;
    logic        off0;
    logic        size_ok;
    logic        aligned;
    logic        wr_go, rd_go, key_go, err_go;

    logic        wr_p1, rd_p1;
    logic [2:0]  size_p1;

    // ERR1 holds HREADY low on the bus, so nothing is sampled there.
    assign addr_vld = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & (state != ERR1);
    assign off0     = (ahb.HADDR[ADDR_W-1:2] == '0);
    assign size_ok  = (ahb.HSIZE <= 3'd2);

    // Natural alignment check for byte / halfword / word
    always_comb begin
        case (ahb.HSIZE)
            3'd1:    aligned = ~ahb.HADDR[0];
            3'd2:    aligned = ~|ahb.HADDR[1:0];
            default: aligned = 1'b1;
        endcase
    end

`ifdef RCC_AHB_LOCK_EN
    localparam logic [31:0] UNLOCK_KEY = 32'hC0DE_5A5A;

    logic        off1;
    logic        key_p1;
    logic        locked;
    logic        locked_eff;

    assign off1 = (ahb.HADDR[ADDR_W-1:2] == (ADDR_W-2)'(1));

    // Lock value as it stands at the end of the data phase now in flight;
    // an address phase overlapping that data phase is decoded against it.
    assign locked_eff = key_p1 ? (ahb.HWDATA != UNLOCK_KEY) :
                        (wr_p1 ? 1'b1 : locked);

    assign wr_go  = addr_vld & off0 & size_ok & aligned &  ahb.HWRITE & ~locked_eff;
    assign rd_go  = addr_vld & off0 & size_ok & aligned & ~ahb.HWRITE;
    assign key_go = addr_vld & off1 & ahb.HWRITE & (ahb.HSIZE == 3'd2) & aligned;

    // Key data phase and lock state; every scale write re-arms the lock
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            key_p1 <= 1'b0;
            locked <= 1'b1;
        end else begin
            key_p1 <= key_go;
            locked <= locked_eff;
        end
    end

    assign LOCKED = locked;
`else
    logic unused_hwdata;

    assign unused_hwdata = ^ahb.HWDATA;
    assign wr_go  = addr_vld & off0 & size_ok & aligned &  ahb.HWRITE;
    assign rd_go  = addr_vld & off0 & size_ok & aligned & ~ahb.HWRITE;
    assign key_go = 1'b0;
    assign LOCKED = 1'b0;
`endif

    assign err_go = addr_vld & ~(wr_go | rd_go | key_go);

    // Response FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= OKAY;
        end else begin
            state <= state_nxt;
        end
    end

    // Response FSM next state and HREADYOUT/HRESP
    always_comb begin
        state_nxt     = state;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = 1'b0;
        case (state)
            OKAY: begin
                if (err_go) state_nxt = ERR1;
            end
            ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = 1'b1;
                state_nxt     = ERR2;
            end
            ERR2: begin
                ahb.HRESP = 1'b1;
                state_nxt = err_go ? ERR1 : OKAY;
            end
            default: state_nxt = OKAY;
        endcase
    end

    // Address phase -> data phase capture (all transfers are zero-wait)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_p1   <= 1'b0;
            rd_p1   <= 1'b0;
            size_p1 <= 3'd0;
        end else begin
            wr_p1   <= wr_go;
            rd_p1   <= rd_go;
            size_p1 <= (wr_go | rd_go) ? ahb.HSIZE : 3'd0;
        end
    end

    assign HSEL_REG   = wr_p1;
    assign HWRITE_REG = wr_p1;
    assign HSIZE_REG  = wr_p1 ? size_p1 : 3'd0;
    assign RD_SEL     = rd_p1;
    assign RD_SIZE    = rd_p1 ? size_p1 : 3'd0;

endmodule

// File: tb/tb_rcc_ahb_if.sv
// Bench for rcc_ahb_if: reset checks, a table of directed vectors, the
// multi-cycle corner sequences, and a randomized run against a
// transaction-level model of the slave.
module tb_rcc_ahb_if;

`ifdef RCC_AHB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam logic [31:0] KEY = 32'hC0DE_5A5A;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL_REG, HWRITE_REG, RD_SEL, LOCKED;
    logic [2:0]  HSIZE_REG, RD_SIZE;
    logic [11:0] act;

    int errors = 0;
    int checks = 0;

    rcc_ahb_if_if #(.ADDR_W(12)) bus ();

    rcc_ahb_if #(.ADDR_W(12)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .ahb        (bus),
        .HSEL_REG   (HSEL_REG),
        .HWRITE_REG (HWRITE_REG),
        .HSIZE_REG  (HSIZE_REG),
        .RD_SEL     (RD_SEL),
        .RD_SIZE    (RD_SIZE),
        .LOCKED     (LOCKED)
    );

    always #5 HCLK = ~HCLK;

    assign act = {bus.HREADYOUT, bus.HRESP, HSEL_REG, HWRITE_REG, HSIZE_REG,
                  RD_SEL, RD_SIZE, LOCKED};

    // {HREADYOUT, HRESP, HSEL_REG, HWRITE_REG, HSIZE_REG, RD_SEL, RD_SIZE, LOCKED}
    function automatic logic [11:0] ev(bit ro, bit rs, bit sel, bit hw,
                                       logic [2:0] hs, bit rd, logic [2:0] rsz, bit lk);
        return {ro, rs, sel, hw, hs, rd, rsz, lk};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (rdy,resp,sel,hw,hs[3],rd,rs[3],lk)",
                     name, act, exp);
        end
    endtask

    task automatic drive(input bit hsel, input logic [11:0] addr, input logic [1:0] trans,
                         input bit write, input logic [2:0] size, input logic [31:0] wdata);
        bus.HSEL   = hsel;
        bus.HADDR  = addr;
        bus.HTRANS = trans;
        bus.HWRITE = write;
        bus.HSIZE  = size;
        bus.HWDATA = wdata;
        bus.HREADY = bus.HREADYOUT;
    endtask

    task automatic step(input bit hsel, input logic [11:0] addr, input logic [1:0] trans,
                        input bit write, input logic [2:0] size, input logic [31:0] wdata);
        drive(hsel, addr, trans, write, size, wdata);
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input logic [31:0] wdata);
        step(1'b0, 12'h000, 2'd0, 1'b0, 3'd0, wdata);
    endtask

    task automatic do_reset();
        drive(1'b0, 12'h000, 2'd0, 1'b0, 3'd0, 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    // Transaction-level model: error countdown, pending data phase, lock bit
    int         m_err;     // 2: first error cycle, 1: second, 0: none
    int         m_pend;    // 0 none, 1 scale write, 2 scale read, 3 key write
    logic [2:0] m_size;
    bit         m_locked;

    task automatic model_reset();
        m_err = 0; m_pend = 0; m_size = 3'd0; m_locked = LOCK_EN;
    endtask

    task automatic model_step();
        bit  lk_now, vld, szok, al;
        int  off, kind;
        lk_now = m_locked;
        if (LOCK_EN) begin
            if (m_pend == 3)      lk_now = (bus.HWDATA != KEY);
            else if (m_pend == 1) lk_now = 1'b1;
        end
        vld  = bus.HSEL && bus.HREADY && bus.HTRANS[1] && (m_err != 2);
        off  = int'(bus.HADDR) / 4;
        szok = bus.HSIZE <= 3'd2;
        al   = (bus.HSIZE == 3'd0) || (bus.HSIZE == 3'd1 && (bus.HADDR % 2) == 0) ||
               (bus.HSIZE == 3'd2 && (bus.HADDR % 4) == 0);
        kind = 0;
        if (off == 0 && szok && al) begin
            if (!bus.HWRITE)              kind = 2;
            else if (!(LOCK_EN && lk_now)) kind = 1;
        end else if (LOCK_EN && off == 1 && bus.HWRITE && bus.HSIZE == 3'd2 && al) begin
            kind = 3;
        end
        if (m_err == 2)            m_err = 1;
        else if (vld && kind == 0) m_err = 2;
        else                       m_err = 0;
        m_pend   = vld ? kind : 0;
        m_size   = bus.HSIZE;
        m_locked = lk_now;
    endtask

    function automatic logic [11:0] model_exp();
        return ev(m_err != 2, m_err != 0, m_pend == 1, m_pend == 1,
                  (m_pend == 1) ? m_size : 3'd0, m_pend == 2,
                  (m_pend == 2) ? m_size : 3'd0, m_locked);
    endfunction

`ifndef RCC_AHB_LOCK_EN
    typedef struct {
        logic        hsel;
        logic [11:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t row(bit hsel, logic [11:0] addr, logic [1:0] trans,
                                 bit write, logic [2:0] size, logic [11:0] exp);
        vec_t v;
        v.hsel = hsel; v.addr = addr; v.trans = trans;
        v.write = write; v.size = size; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[23];
`endif

    logic [11:0] idle_exp;
    logic [11:0] a_pick[9];

    initial begin
        drive(1'b0, 12'h000, 2'd0, 1'b0, 3'd0, 32'd0);
        HRESETn = 1'b0;
        #1;
        idle_exp = ev(1, 0, 0, 0, 3'd0, 0, 3'd0, LOCK_EN);
        check("reset_async", idle_exp);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        check("reset_hold", idle_exp);
        HRESETn = 1'b1;

        // Reset pulsed while the slave sits in ERR1
        step(1'b1, 12'h001, 2'd2, 1'b1, 3'd1, 32'd0);
        check("rst_err1_entry", ev(0, 1, 0, 0, 3'd0, 0, 3'd0, LOCK_EN));
        drive(1'b0, 12'h000, 2'd0, 1'b0, 3'd0, 32'd0);
        HRESETn = 1'b0;
        #1;
        check("rst_mid_err1", idle_exp);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(32'd0);
        check("rst_release_1", idle_exp);
        idle(32'd0);
        check("rst_release_2", idle_exp);

`ifndef RCC_AHB_LOCK_EN
        tbl[0]  = row(1, 12'h000, 2'd2, 1, 3'd2, ev(1, 0, 1, 1, 3'd2, 0, 3'd0, 0));
        tbl[1]  = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[2]  = row(1, 12'h001, 2'd2, 1, 3'd1, ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[3]  = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[4]  = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[5]  = row(1, 12'h000, 2'd2, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 1, 3'd0, 0));
        tbl[6]  = row(1, 12'h000, 2'd2, 1, 3'd0, ev(1, 0, 1, 1, 3'd0, 0, 3'd0, 0));
        tbl[7]  = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[8]  = row(1, 12'h008, 2'd2, 0, 3'd2, ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[9]  = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[10] = row(1, 12'h000, 2'd2, 1, 3'd2, ev(1, 0, 1, 1, 3'd2, 0, 3'd0, 0));
        tbl[11] = row(1, 12'h000, 2'd1, 1, 3'd2, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[12] = row(1, 12'h002, 2'd3, 1, 3'd1, ev(1, 0, 1, 1, 3'd1, 0, 3'd0, 0));
        tbl[13] = row(1, 12'h003, 2'd2, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 1, 3'd0, 0));
        tbl[14] = row(1, 12'h000, 2'd2, 0, 3'd3, ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[15] = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[16] = row(1, 12'h100, 2'd2, 0, 3'd2, ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[17] = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[18] = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[19] = row(1, 12'h004, 2'd2, 1, 3'd2, ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[20] = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 1, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[21] = row(0, 12'h000, 2'd0, 0, 3'd0, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        tbl[22] = row(0, 12'h000, 2'd2, 1, 3'd2, ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].hsel, tbl[i].addr, tbl[i].trans, tbl[i].write, tbl[i].size, 32'd0);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
`else
        // Locked write refused, key unlocks, scale write re-locks
        step(1'b1, 12'h000, 2'd2, 1'b1, 3'd2, 32'd0);
        check("lock_wr_err1", ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 1));
        idle(32'd0);
        check("lock_wr_err2", ev(1, 1, 0, 0, 3'd0, 0, 3'd0, 1));
        idle(32'd0);
        check("lock_wr_okay", ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 1));
        step(1'b1, 12'h004, 2'd2, 1'b1, 3'd2, 32'd0);
        check("key_addr", ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 1));
        idle(KEY);
        check("key_unlock", ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 0));
        step(1'b1, 12'h000, 2'd2, 1'b1, 3'd2, 32'd0);
        check("unlocked_wr", ev(1, 0, 1, 1, 3'd2, 0, 3'd0, 0));
        idle(32'd0);
        check("relock", ev(1, 0, 0, 0, 3'd0, 0, 3'd0, 1));
        step(1'b1, 12'h004, 2'd2, 1'b0, 3'd2, 32'd0);
        check("key_read_err", ev(0, 1, 0, 0, 3'd0, 0, 3'd0, 1));
        idle(32'd0);
        idle(32'd0);
        step(1'b1, 12'h000, 2'd2, 1'b0, 3'd2, 32'd0);
        check("locked_read_ok", ev(1, 0, 0, 0, 3'd0, 1, 3'd2, 1));
`endif

        // Randomized traffic against the model
        a_pick[0] = 12'h000; a_pick[1] = 12'h001; a_pick[2] = 12'h002;
        a_pick[3] = 12'h003; a_pick[4] = 12'h004; a_pick[5] = 12'h008;
        a_pick[6] = 12'h100; a_pick[7] = 12'hFFC; a_pick[8] = 12'h006;
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) != 0, a_pick[$urandom % 9], 2'($urandom % 4),
                  1'($urandom % 2), 3'($urandom % 5),
                  (($urandom % 2) != 0) ? KEY : $urandom);
            bus.HREADY = bus.HREADYOUT & (($urandom % 8) != 0);
            model_step();
            @(posedge HCLK);
            #1;
            check($sformatf("rand%0d", n), model_exp());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
